// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder that processes DIGIT bits per clock,
// LSB slice first, and returns the sum, carry-out, signed overflow and
// zero flag after WIDTH/DIGIT cycles.
// Optional feature: define SERIAL_ADDER_SUB_EN to add a 'sub' input
// (a - b computed as a + ~b + 1).
module serial_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zf
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // Reject parameter sets that do not split WIDTH into whole digits.
    if (DIGIT == 0 || WIDTH == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q, zf_q;

    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;
    logic [DIGIT-1:0] slice_sum;
    logic [DIGIT:0]   chain;

    assign last = (cnt_q == CNT_LAST);

    // Operand B and carry-in as they are latched; subtraction folds into addition.
    always_comb begin
        b_load   = b;
        cin_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load   = ~b;
            cin_load = 1'b1;
        end
`endif
    end

    // Next-state logic: accept start in IDLE/DONE, count N slices in RUN.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // DIGIT-bit ripple chain of full adders over the current low slice.
    always_comb begin
        chain     = '0;
        slice_sum = '0;
        chain[0]  = carry_q;
        for (int i = 0; i < int'(DIGIT); i++) begin
            slice_sum[i] = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // Accumulator: new slice enters at the top, earlier slices shift down.
    always_comb begin
        acc_d = (acc_q >> DIGIT) | (WIDTH'(slice_sum) << (WIDTH - DIGIT));
    end

    // FSM state and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    // Operand shift registers, carry register, slice counter and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b_load;
            acc_q   <= '0;
            carry_q <= cin_load;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            acc_q   <= acc_d;
            carry_q <= chain[DIGIT];
            cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Result registers: written only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zf_q   <= 1'b0;
        end else if (step && last) begin
            s_q    <= acc_d;
            cout_q <= chain[DIGIT];
            ovf_q  <= chain[DIGIT] ^ chain[DIGIT-1];
            zf_q   <= (acc_d == '0);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign zf   = zf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed bench for serial_adder with an 8-bit/4-bit
// instance and a 1-bit/1-bit instance sharing clock and reset.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8, zf8;
    logic [7:0] s8;

    logic       start1, cin1, sub1;
    logic [0:0] a1, b1;
    logic       busy1, done1, cout1, ovf1, zf1;
    logic [0:0] s1;

    int checks = 0;
    int errors = 0;
    int lat;

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .start(start8),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub  (sub8),
`endif
        .busy (busy8),
        .done (done8),
        .s    (s8),
        .cout (cout8),
        .ovf  (ovf8),
        .zf   (zf8)
    );

    serial_adder #(.WIDTH(1), .DIGIT(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .start(start1),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub  (sub1),
`endif
        .busy (busy1),
        .done (done1),
        .s    (s1),
        .cout (cout1),
        .ovf  (ovf1),
        .zf   (zf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect8(input string tag, input logic [7:0] es, input logic ec,
                           input logic eo, input logic ez);
        check({tag, " s"},    32'(s8),    32'(es));
        check({tag, " cout"}, 32'(cout8), 32'(ec));
        check({tag, " ovf"},  32'(ovf8),  32'(eo));
        check({tag, " zf"},   32'(zf8),   32'(ez));
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic sb, output int l);
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        cin8   = ci;
        sub8   = sb;
        l      = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (done8) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic op1(input logic av, input logic bv, input logic ci, output int l);
        start1 = 1'b1;
        a1     = av;
        b1     = bv;
        cin1   = ci;
        l      = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1) begin
                l = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst busy8", 32'(busy8), 32'd0);
        check("rst done8", 32'(done8), 32'd0);
        expect8("rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst done1", 32'(done1), 32'd0);
        rst = 1'b0;

        // Wrap-around to zero; done two edges after the start edge.
        op8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        check("lat ff+01", 32'(lat), 32'd3);
        check("busy at done", 32'(busy8), 32'd0);
        expect8("ff+01", 8'h00, 1'b1, 1'b0, 1'b1);

        op8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        check("lat 7f+01", 32'(lat), 32'd3);
        expect8("7f+01", 8'h80, 1'b0, 1'b1, 1'b0);

        op8(8'h80, 8'h80, 1'b0, 1'b0, lat);
        expect8("80+80", 8'h00, 1'b1, 1'b1, 1'b1);

        op8(8'h12, 8'h34, 1'b1, 1'b0, lat);
        expect8("12+34+1", 8'h47, 1'b0, 1'b0, 1'b0);

        op8(8'hC8, 8'h64, 1'b0, 1'b0, lat);
        expect8("c8+64", 8'h2C, 1'b1, 1'b0, 1'b0);

        op8(8'h0F, 8'h01, 1'b0, 1'b0, lat);
        expect8("0f+01", 8'h10, 1'b0, 1'b0, 1'b0);

        op8(8'hFF, 8'h00, 1'b1, 1'b0, lat);
        expect8("ff+00+1", 8'h00, 1'b1, 1'b0, 1'b1);

        // Done lasts one cycle and results hold afterwards.
        @(negedge clk);
        check("done pulse width", 32'(done8), 32'd0);
        repeat (3) @(negedge clk);
        check("hold busy", 32'(busy8), 32'd0);
        expect8("hold", 8'h00, 1'b1, 1'b0, 1'b1);

        // Start while busy is ignored and does not disturb the operands.
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55;
        check("busy after start", 32'(busy8), 32'd1);
        @(negedge clk);
        start8 = 1'b0;
        check("no early done", 32'(done8), 32'd0);
        @(negedge clk);
        check("done ignore", 32'(done8), 32'd1);
        expect8("10+20 ignore", 8'h30, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("no second done", 32'(done8), 32'd0);
        check("s held 30", 32'(s8), 32'h30);

        // Back-to-back: the second start lands in the DONE cycle.
        op8(8'h01, 8'h02, 1'b0, 1'b0, lat);
        expect8("01+02", 8'h03, 1'b0, 1'b0, 1'b0);
        op8(8'h03, 8'h04, 1'b0, 1'b0, lat);
        check("lat back-to-back", 32'(lat), 32'd3);
        expect8("03+04", 8'h07, 1'b0, 1'b0, 1'b0);

        // Reset mid-RUN clears outputs at once and suppresses done.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h21; b8 = 8'h21;
        @(negedge clk);
        start8 = 1'b0;
        check("busy before rst", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("rst mid busy", 32'(busy8), 32'd0);
        check("rst mid done", 32'(done8), 32'd0);
        expect8("rst mid", 8'h00, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no done in rst", 32'(done8), 32'd0);
        end
        rst = 1'b0;
        op8(8'h21, 8'h21, 1'b0, 1'b0, lat);
        check("lat after rst", 32'(lat), 32'd3);
        expect8("21+21", 8'h42, 1'b0, 1'b0, 1'b0);

        // Single-bit instance: done one cycle after the start edge.
        op1(1'b1, 1'b1, 1'b0, lat);
        check("w1 lat 1+1", 32'(lat), 32'd2);
        check("w1 1+1 s",    32'(s1),    32'd0);
        check("w1 1+1 cout", 32'(cout1), 32'd1);
        check("w1 1+1 ovf",  32'(ovf1),  32'd1);
        check("w1 1+1 zf",   32'(zf1),   32'd1);
        op1(1'b1, 1'b0, 1'b0, lat);
        check("w1 lat 1+0", 32'(lat), 32'd2);
        check("w1 1+0 s",    32'(s1),    32'd1);
        check("w1 1+0 cout", 32'(cout1), 32'd0);
        check("w1 1+0 ovf",  32'(ovf1),  32'd0);
        check("w1 1+0 zf",   32'(zf1),   32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction ignores cin.
        op8(8'h05, 8'h07, 1'b1, 1'b1, lat);
        expect8("05-07", 8'hFE, 1'b0, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 1'b1, lat);
        expect8("80-01", 8'h7F, 1'b1, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
